rr_arb_forward_reg: RTL and testbench
=====================================

RR_ARB_FORWARD_REG -- requirements
Module: rr_arb_forward_reg

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (legal 2..16).
REQ-002 SHALL have parameter W, default 8, payload width in bits.
REQ-003 SHALL define SW = max(1, clog2(N)) as the source-index width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  N  per-requester valid; bit i belongs to requester i.
REQ-007 SHALL have port in_ready  output  N  per-requester ready.
REQ-008 SHALL have port in_payload  input  N*W  requester i occupies bits [i*W +: W].
REQ-009 SHALL have port in_last  input  N  per-requester end-of-burst flag.
REQ-010 SHALL have port out_valid  output  1  registered output valid.
REQ-011 SHALL have port out_ready  input  1  downstream ready.
REQ-012 SHALL have port out_payload  output  W  registered payload.
REQ-013 SHALL have port out_last  output  1  registered last flag.
REQ-014 SHALL have port out_src  output  SW  registered index of the winning requester.

Function
REQ-015 SHALL compute accept = ~out_valid | out_ready, combinationally.
REQ-016 SHALL hold at most one in_ready bit high in any cycle.
REQ-017 SHALL drive in_ready[i] = accept & grant[i]; all bits SHALL be 0 when accept = 0.
REQ-018 When unlocked, SHALL assert grant for the first i with in_valid[i] = 1, scanning ptr, ptr+1, ... modulo N.
REQ-019 When locked, SHALL assert grant only for lock_src, and only if in_valid[lock_src] = 1; no other requester is granted, even if lock_src is idle.
REQ-020 A transfer occurs when in_valid[i] & in_ready[i]; it SHALL load payload, last and src = i into the output register and set out_valid = 1 on the next edge.
REQ-021 With no transfer and out_ready = 1, SHALL clear out_valid on the next edge; otherwise the output register SHALL hold.
REQ-022 SHALL sustain 1 beat per cycle with out_ready held at 1; latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-023 A transfer with in_last = 0 SHALL set lock = 1 and lock_src = i.
REQ-024 A transfer with in_last = 1 SHALL clear lock and set ptr = (i + 1) mod N.
REQ-025 A transfer with in_last = 0 SHALL leave ptr unchanged.
REQ-026 Output register contents SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-027 With no in_valid bit set, SHALL leave lock and ptr unchanged.
REQ-028 The grant decision SHALL depend only on in_valid, ptr, lock, lock_src and accept; in_ready may depend combinationally on in_valid, but in_valid SHALL never be required to depend on in_ready.

Reset
REQ-029 When rst_n = 0 at an edge, SHALL set out_valid = 0, out_payload = 0, out_last = 0, out_src = 0, lock = 0, lock_src = 0, ptr = 0.
REQ-030 While rst_n = 0, SHALL drive in_ready = 0.
REQ-031 Reset asserted mid-burst SHALL discard the buffered beat and the lock; the first grant after reset SHALL follow REQ-018 from ptr = 0.

Verification
REQ-032 All 4 requesters valid with last = 1, out_ready = 1 -> out_src sequence 0,1,2,3,0, one beat per cycle, first out_valid 1 cycle after release from reset.
REQ-033 Req 1 sends a 3-beat burst (last on beat 3) while req 0 and req 2 are valid -> out_src = 1,1,1, then 2, then 0; in_ready[0] and in_ready[2] stay 0 during the burst.
REQ-034 Req 3 is locked and drops in_valid for 2 cycles mid-burst while req 0 is valid -> no grants in those cycles; burst resumes on req 3; req 0 is granted after req 3's last beat.
REQ-035 out_valid = 1 holding payload 0xA5, out_ready = 0 for 3 cycles -> in_ready = 0, and out_payload stays 0xA5 and out_src stays unchanged each cycle; when out_ready rises, a new beat is accepted in the same cycle.
REQ-036 rst_n pulsed low for 1 cycle during a locked burst from req 2 -> out_valid = 0 next cycle, lock cleared; with req 0 and req 2 valid, the next grant is req 0.
REQ-037 Single requester 2 streaming with out_ready toggling 1,0,1,0 -> no beat lost or duplicated, and payload order is preserved.

Source files
------------

// File: rtl/rr_arb_forward_reg.sv
// Round-robin arbiter with burst locking, feeding one registered output slot.
// Grant scans from a rotating pointer; a burst holds the grant until its last beat.
module rr_arb_forward_reg #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_payload,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_payload,
    output logic           out_last,
    output logic [SW-1:0]  out_src
);

    logic [SW-1:0] ptr;
    logic          lock;
    logic [SW-1:0] lock_src;

    logic          accept;
    logic [N-1:0]  grant;
    logic          xfer;
    logic [SW-1:0] sel_src;
    logic [W-1:0]  sel_payload;
    logic          sel_last;
    logic [SW:0]   idx;
    logic          found;

    assign accept = ~out_valid | out_ready;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (lock) begin
            grant[lock_src] = in_valid[lock_src];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = {1'b0, ptr} + (SW+1)'(k);
                if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
                if (!found && in_valid[idx[SW-1:0]]) begin
                    grant[idx[SW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    assign in_ready = (rst_n && accept) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        sel_src     = '0;
        sel_payload = '0;
        sel_last    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_src     = SW'(i);
                sel_payload = in_payload[i*W +: W];
                sel_last    = in_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_last    <= 1'b0;
            out_src     <= '0;
            lock        <= 1'b0;
            lock_src    <= '0;
            ptr         <= '0;
        end else if (xfer) begin
            out_valid   <= 1'b1;
            out_payload <= sel_payload;
            out_last    <= sel_last;
            out_src     <= sel_src;
            if (sel_last) begin
                // End of burst releases the lock and rotates priority past the winner.
                lock <= 1'b0;
                ptr  <= (sel_src == SW'(N-1)) ? '0 : sel_src + SW'(1);
            end else begin
                lock     <= 1'b1;
                lock_src <= sel_src;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_forward_reg.sv
// Randomized and directed bench for rr_arb_forward_reg with a queue scoreboard.
// The reference model tracks pointer/lock/slot occupancy and predicts each beat.
module tb_rr_arb_forward_reg;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_payload;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_payload;
    logic           out_last;
    logic [SW-1:0]  out_src;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int       src;
        logic [7:0] payload;
        logic     last;
    } beat_t;
    beat_t exp_q[$];

    logic [7:0] base [N];
    logic [7:0] sent [N];
    int         blen [N];

    // Model state
    int  m_ptr = 0;
    bit  m_lock = 0;
    int  m_src = 0;
    bit  m_v = 0;

    // Previous-cycle snapshot for stall stability
    bit         p_hold = 0;
    logic [7:0] p_payload;
    logic [SW-1:0] p_src;
    logic       p_last;

    rr_arb_forward_reg #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_last(out_last), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each requester streams base+count payloads; last marks every blen-th beat.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_payload[i*W +: W] = base[i] + sent[i];
            in_last[i] = (((int'(sent[i]) + 1) % blen[i]) == 0);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (rst_n && in_valid[i] && in_ready[i]) sent[i] <= sent[i] + 8'd1;
    end

    // Reference model: predicts ready, the next edge's transfer and slot occupancy.
    always @(negedge clk) begin
        int g;
        bit acc;
        logic [N-1:0] exp_ready;
        if (!rst_n) begin
            check("in_ready_in_reset", 32'(in_ready), 32'd0);
            m_ptr = 0; m_lock = 0; m_src = 0; m_v = 0;
            exp_q.delete();
        end else begin
            check("out_valid", 32'(out_valid), 32'(m_v));
            acc = !m_v || out_ready;
            g = -1;
            if (m_lock) begin
                if (in_valid[m_src]) g = m_src;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (g < 0 && in_valid[j]) g = j;
                end
            end
            exp_ready = '0;
            if (acc && g >= 0) exp_ready[g] = 1'b1;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            if (acc && g >= 0) begin
                beat_t b;
                b.src = g;
                b.payload = base[g] + sent[g];
                b.last = in_last[g];
                exp_q.push_back(b);
                if (b.last) begin
                    m_lock = 0;
                    m_ptr = (g + 1) % N;
                end else begin
                    m_lock = 1;
                    m_src = g;
                end
                m_v = 1;
            end else if (out_ready) begin
                m_v = 0;
            end
        end
    end

    // Monitor: pops a predicted beat on every output handshake.
    always @(negedge clk) begin
        if (rst_n && p_hold) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_payload", 32'(out_payload), 32'(p_payload));
            check("stall_src", 32'(out_src), 32'(p_src));
            check("stall_last", 32'(out_last), 32'(p_last));
        end
        p_hold = rst_n && out_valid && !out_ready;
        p_payload = out_payload; p_src = out_src; p_last = out_last;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("out_src", 32'(out_src), 32'(b.src));
                check("out_payload", 32'(out_payload), 32'(b.payload));
                check("out_last", 32'(out_last), 32'(b.last));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            base[i] = 8'(i * 64); sent[i] = 8'd0; blen[i] = 1;
        end
        cyc(2);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_payload", 32'(out_payload), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        @(posedge clk); #1;

        // All four requesters, single-beat packets, full throughput
        in_valid = 4'hF; out_ready = 1'b1; rst_n = 1'b1;
        cyc(6);

        // Req 1 three-beat burst with reqs 0 and 2 competing
        in_valid = '0; cyc(2);
        blen[1] = 3 - (int'(sent[1]) % 3) + 0; blen[1] = 3;
        sent[1] = 8'd0;
        in_valid = 4'b0010; cyc(1);
        in_valid = 4'b0111; cyc(6);
        in_valid = '0; blen[1] = 1; cyc(2);

        // Req 3 locked, drops valid for two cycles mid-burst while req 0 waits
        blen[3] = 3; sent[3] = 8'd0;
        in_valid = 4'b1000; cyc(1);
        in_valid = 4'b0001; cyc(2);
        in_valid = 4'b1001; cyc(4);
        in_valid = '0; blen[3] = 1; cyc(2);

        // Output stall holding 0xA5
        base[1] = 8'hA5 - sent[1];
        in_valid = 4'b0010; cyc(1);
        out_ready = 1'b0; cyc(3);
        out_ready = 1'b1; cyc(2);
        in_valid = '0; cyc(2);

        // Reset pulse during a locked burst from req 2
        blen[2] = 3; sent[2] = 8'd0;
        in_valid = 4'b0100; cyc(1);
        in_valid = 4'b0101; rst_n = 1'b0; cyc(1);
        rst_n = 1'b1; cyc(4);
        in_valid = '0; blen[2] = 1; cyc(2);

        // Single requester with toggling backpressure
        in_valid = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            out_ready = i[0] ? 1'b0 : 1'b1;
            cyc(1);
        end
        out_ready = 1'b1; in_valid = '0; cyc(2);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0)
                for (int i = 0; i < N; i++) blen[i] = int'($urandom_range(1, 3));
            in_valid  = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            rst_n     = (c != 217);
            cyc(1);
        end

        rst_n = 1'b1; in_valid = '0; out_ready = 1'b1;
        cyc(4);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
